match_tracker: RTL and testbench

- Sits directly downstream of the scorer, in parallel with the LED mux.
- Watches the 7-bit one-hot rope position `score` and detects when a game ends, i.e. the rope reaches an end LED.
- Keeps a per-player game tally and declares a match winner after WINS_TO_MATCH games.
- Issues a one-cycle `game_reset` request so the top level can re-centre the scorer for the next game.

---
 rtl/match_tracker_pkg.sv | 24 ++
 rtl/match_tracker_hold_timer.sv | 59 +++++
 rtl/match_tracker.sv | 194 +++++++++++++++++++
 tb/tb_match_tracker.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/match_tracker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : match_tracker_pkg
//  Description : Shared game constants for the rope-pull game: one-hot rope
//                positions reported by the scorer and the match-tracker
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package match_tracker_pkg;

    // One-hot rope positions (bit6 = left end, bit0 = right end)
    localparam logic [6:0] SCORE_CENTRE    = 7'b0001000;
    localparam logic [6:0] SCORE_LEFT_END  = 7'b1000000;
    localparam logic [6:0] SCORE_RIGHT_END = 7'b0000001;

    // Match-tracker state encoding
    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        GAME_END  = 2'd1,
        MATCH_END = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/match_tracker_hold_timer.sv
`default_nettype none
// ============================================================================
//  Module      : match_tracker_hold_timer
//  Description : Hold timer for end-of-game display timing. Counts
//                0..HOLD_CYCLES-1 while run is high and wraps, flags the
//                last count with a terminal-count pulse, and derives a
//                blink signal that toggles at each quarter of the period.
//  Ports       : clk   - game clock
//                rst   - asynchronous active-low reset
//                clear - synchronous clear of count and blink (wins over run)
//                run   - advance the count this cycle
//                tc    - high while running on the final count
//                blink - quarter-period toggle output
//  Revision    : 1.0 - initial release
// ============================================================================
module match_tracker_hold_timer #(
    parameter int HOLD_CYCLES = 500,
    parameter int HOLD_W      = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic tc,
    output logic blink
);

    localparam logic [HOLD_W-1:0] c_last = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] c_q1   = HOLD_W'(HOLD_CYCLES / 4);
    localparam logic [HOLD_W-1:0] c_q2   = HOLD_W'(HOLD_CYCLES / 2);
    localparam logic [HOLD_W-1:0] c_q3   = HOLD_W'((3 * HOLD_CYCLES) / 4);

    logic [HOLD_W-1:0] r_count;
    logic              r_blink;
    logic              w_toggle;

    assign tc       = run & (r_count == c_last);
    assign w_toggle = run & ((r_count == '0)   || (r_count == c_q1) ||
                             (r_count == c_q2) || (r_count == c_q3));
    assign blink    = r_blink;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            r_blink <= 1'b0;
        end else if (clear) begin
            r_count <= '0;
            r_blink <= 1'b0;
        end else if (run) begin
            // Wrap on the last count so the blink keeps running indefinitely
            r_count <= tc ? '0 : r_count + HOLD_W'(1);
            if (w_toggle) begin
                r_blink <= ~r_blink;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/match_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : match_tracker
//  Description : Watches the one-hot rope position from the scorer, counts
//                games won by each player, declares a match winner after
//                WINS_TO_MATCH games and requests a scorer re-centre with a
//                one-cycle game_reset pulse after each game.
//  Ports       : clk          - 500 Hz game clock
//                rst          - asynchronous active-low reset
//                score[6:0]   - one-hot rope position (bit6 left end)
//                new_match    - clear tallies and start a new match
//                game_reset   - one-cycle scorer re-centre request
//                left_games   - games won by left player
//                right_games  - games won by right player
//                match_over   - match winner latched
//                match_winner - 1 = left, 0 = right (valid with match_over)
//                blink        - end-of-game/match display blink
//                bad_score    - sticky: non-one-hot score seen in PLAY
//  Revision    : 1.0 - initial release
// ============================================================================
module match_tracker
    import match_tracker_pkg::*;
#(
    parameter int WINS_TO_MATCH = 3,
    parameter int HOLD_CYCLES   = 500,
    parameter int HOLD_W        = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] score,
    input  logic       new_match,
    output logic       game_reset,
    output logic [3:0] left_games,
    output logic [3:0] right_games,
    output logic       match_over,
    output logic       match_winner,
    output logic       blink,
    output logic       bad_score
);

    localparam logic [3:0] c_wins = 4'(WINS_TO_MATCH);

    state_t     r_state;
    state_t     w_next_state;
    logic [6:0] r_score_q;

    logic w_left_end;
    logic w_right_end;
    logic w_not_onehot;
    logic w_left_inc;
    logic w_right_inc;
    logic w_win;
    logic w_winner;
    logic w_set_bad;
    logic w_game_reset;
    logic w_timer_clear;
    logic w_timer_run;
    logic w_timer_tc;
    logic w_timer_blink;

    // Rising-edge detection: a rope parked at an end counts only once
    assign w_left_end   = score[6] & ~r_score_q[6];
    assign w_right_end  = score[0] & ~r_score_q[0];
    assign w_not_onehot = ($countones(score) != 1);

    // Timer idles at zero in PLAY so every GAME_END/MATCH_END starts fresh
    assign w_timer_clear = new_match | (r_state == PLAY);
    assign w_timer_run   = (r_state != PLAY);

    match_tracker_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .HOLD_W      (HOLD_W)
    ) u_hold_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (w_timer_clear),
        .run   (w_timer_run),
        .tc    (w_timer_tc),
        .blink (w_timer_blink)
    );

    assign blink = w_timer_blink & (r_state != PLAY);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= PLAY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_left_inc   = 1'b0;
        w_right_inc  = 1'b0;
        w_win        = 1'b0;
        w_winner     = 1'b0;
        w_set_bad    = 1'b0;
        w_game_reset = 1'b0;

        if (new_match) begin
            // New match wins over any end event seen this cycle
            w_next_state = PLAY;
            w_game_reset = 1'b1;
        end else begin
            case (r_state)
                PLAY: begin
                    w_set_bad = w_not_onehot;
                    if (w_left_end && w_right_end) begin
                        // Both ends at once is an illegal score; no tally
                        w_set_bad = 1'b1;
                    end else if (w_left_end) begin
                        w_left_inc = 1'b1;
                        if (left_games + 4'd1 == c_wins) begin
                            w_next_state = MATCH_END;
                            w_win        = 1'b1;
                            w_winner     = 1'b1;
                        end else begin
                            w_next_state = GAME_END;
                        end
                    end else if (w_right_end) begin
                        w_right_inc = 1'b1;
                        if (right_games + 4'd1 == c_wins) begin
                            w_next_state = MATCH_END;
                            w_win        = 1'b1;
                            w_winner     = 1'b0;
                        end else begin
                            w_next_state = GAME_END;
                        end
                    end
                end
                GAME_END: begin
                    if (w_timer_tc) begin
                        w_next_state = PLAY;
                        w_game_reset = 1'b1;
                    end
                end
                MATCH_END: begin
                    w_next_state = MATCH_END;
                end
                default: begin
                    w_next_state = PLAY;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Tallies, flags and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_score_q    <= SCORE_CENTRE;
            game_reset   <= 1'b0;
            left_games   <= 4'd0;
            right_games  <= 4'd0;
            match_over   <= 1'b0;
            match_winner <= 1'b0;
            bad_score    <= 1'b0;
        end else begin
            r_score_q  <= score;
            game_reset <= w_game_reset;
            if (new_match) begin
                left_games   <= 4'd0;
                right_games  <= 4'd0;
                match_over   <= 1'b0;
                match_winner <= 1'b0;
                bad_score    <= 1'b0;
            end else begin
                if (w_left_inc) begin
                    left_games <= left_games + 4'd1;
                end
                if (w_right_inc) begin
                    right_games <= right_games + 4'd1;
                end
                if (w_win) begin
                    match_over   <= 1'b1;
                    match_winner <= w_winner;
                end
                if (w_set_bad) begin
                    bad_score <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_match_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_match_tracker
//  Description : Scoreboard bench for match_tracker. Stimulus pushes expected
//                game_reset pulse times and output snapshots into queues; a
//                negedge monitor pops and compares them against the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_match_tracker;

    localparam int HOLD = 500;
    localparam logic [6:0] CEN   = 7'b0001000;
    localparam logic [6:0] LEFT  = 7'b1000000;
    localparam logic [6:0] RIGHT = 7'b0000001;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] score;
    logic       new_match;
    logic       game_reset;
    logic [3:0] left_games;
    logic [3:0] right_games;
    logic       match_over;
    logic       match_winner;
    logic       blink;
    logic       bad_score;

    match_tracker #(
        .WINS_TO_MATCH (3),
        .HOLD_CYCLES   (HOLD),
        .HOLD_W        (9)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .score        (score),
        .new_match    (new_match),
        .game_reset   (game_reset),
        .left_games   (left_games),
        .right_games  (right_games),
        .match_over   (match_over),
        .match_winner (match_winner),
        .blink        (blink),
        .bad_score    (bad_score)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string name;
        int    cyc;
    } pulse_t;

    // -1 in a field means "don't care"
    typedef struct {
        string name;
        int    left;
        int    right;
        int    mo;
        int    win;
        int    bad;
        int    blk;
    } snap_t;

    pulse_t q_pulse[$];
    snap_t  q_snap[$];

    int total = 0;
    int nbad  = 0;

    task automatic chk(input string name, input int act, input int exp);
        if (exp >= 0) begin
            total++;
            if (act != exp) begin
                nbad++;
                $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
            end
        end
    endtask

    task automatic expect_pulse(input string name, input int at);
        pulse_t p;
        p.name = name;
        p.cyc  = at;
        q_pulse.push_back(p);
    endtask

    task automatic expect_snap(input string name, input int l, input int r,
                               input int mo, input int w, input int b, input int bl);
        snap_t s;
        s.name = name; s.left = l; s.right = r; s.mo = mo;
        s.win = w; s.bad = b; s.blk = bl;
        q_snap.push_back(s);
    endtask

    // Any expected pulse whose time has passed was never seen
    task automatic check_missing();
        while (q_pulse.size() > 0 && q_pulse[0].cyc < cyc) begin
            pulse_t p;
            p = q_pulse.pop_front();
            total++;
            nbad++;
            $display("FAIL %s: game_reset missing, expected at cycle %0d, now %0d", p.name, p.cyc, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compares pulses and snapshots away from the active edge
    always @(negedge clk) begin
        if (game_reset === 1'b1) begin
            if (q_pulse.size() == 0) begin
                total++;
                nbad++;
                $display("FAIL unexpected_game_reset: got pulse at cycle %0d expected none", cyc);
            end else begin
                pulse_t p;
                p = q_pulse.pop_front();
                chk({p.name, "_cycle"}, cyc, p.cyc);
            end
        end
        while (q_snap.size() > 0) begin
            snap_t s;
            s = q_snap.pop_front();
            chk({s.name, "_left"},   int'(left_games),   s.left);
            chk({s.name, "_right"},  int'(right_games),  s.right);
            chk({s.name, "_over"},   int'(match_over),   s.mo);
            chk({s.name, "_winner"}, int'(match_winner), s.win);
            chk({s.name, "_bad"},    int'(bad_score),    s.bad);
            chk({s.name, "_blink"},  int'(blink),        s.blk);
        end
    end

    initial begin
        rst       = 1'b0;
        score     = CEN;
        new_match = 1'b0;
        step(2);
        expect_snap("reset", 0, 0, 0, 0, 0, 0);
        step(1);
        chk("reset_game_reset", int'(game_reset), 0);
        rst = 1'b1;
        step(2);

        // Left-end arrival, pulse HOLD+1 cycles after the event cycle
        score = 7'b0100000;
        step(1);
        score = LEFT;
        expect_pulse("game1", cyc + HOLD + 1);
        step(1);
        expect_snap("left_end", 1, 0, 0, 0, 0, 0);
        step(1);
        expect_snap("blink_on", 1, 0, 0, 0, 0, 1);
        step(510);
        check_missing();

        // Rope parked at the left end: no re-count
        step(2000);
        expect_snap("parked", 1, 0, 0, 0, 0, 0);
        step(1);

        // Fresh match, then three right wins
        new_match = 1'b1;
        expect_pulse("nm1", cyc + 1);
        step(1);
        new_match = 1'b0;
        expect_snap("nm1_clear", 0, 0, 0, 0, 0, 0);
        step(1);
        score = CEN;
        step(2);
        for (int i = 0; i < 3; i++) begin
            score = RIGHT;
            if (i < 2) begin
                expect_pulse("right_game", cyc + HOLD + 1);
                step(511);
            end else begin
                step(2);
            end
            score = CEN;
            step(2);
        end
        expect_snap("match", 0, 3, 1, 0, 0, -1);
        step(1);
        score = LEFT;
        step(600);
        expect_snap("frozen", 0, 3, 1, 0, 0, -1);
        step(1);
        check_missing();

        // Illegal two-hot score
        new_match = 1'b1;
        expect_pulse("nm2", cyc + 1);
        step(1);
        new_match = 1'b0;
        score = CEN;
        step(2);
        score = 7'b1000001;
        step(1);
        expect_snap("bad", 0, 0, 0, 0, 1, 0);
        step(1);
        new_match = 1'b1;
        score = CEN;
        expect_pulse("nm3", cyc + 1);
        step(1);
        new_match = 1'b0;
        expect_snap("bad_clear", 0, 0, 0, 0, 0, 0);
        step(2);

        // Two left wins, then new_match in the same cycle as the third
        for (int i = 0; i < 2; i++) begin
            score = LEFT;
            expect_pulse("left_game", cyc + HOLD + 1);
            step(511);
            score = CEN;
            step(2);
        end
        expect_snap("left2", 2, 0, 0, 0, 0, 0);
        step(1);
        score = LEFT;
        new_match = 1'b1;
        expect_pulse("nm_vs_end", cyc + 1);
        step(1);
        new_match = 1'b0;
        expect_snap("nm_vs_end", 0, 0, 0, 0, 0, 0);
        step(600);
        expect_snap("nm_vs_end_later", 0, 0, 0, 0, 0, 0);
        step(1);
        check_missing();

        // Reset in the middle of GAME_END
        score = CEN;
        step(2);
        score = RIGHT;
        step(250);
        expect_snap("pre_rst", 0, 1, 0, 0, 0, -1);
        step(1);
        rst = 1'b0;
        expect_snap("async_rst", 0, 0, 0, 0, 0, 0);
        step(3);
        score = CEN;
        rst = 1'b1;
        step(700);
        expect_snap("post_rst", 0, 0, 0, 0, 0, 0);
        step(1);
        check_missing();

        $display("test done: total=%0d bad=%0d", total, nbad);
        $finish;
    end

endmodule
`default_nettype wire
